// File: rtl/uart_tx_frame_ctrl.sv
// UART transmitter with control FSM, baud divider and shift register.
// Sends start bit, DATA_W data bits (LSB first), optional parity and one or
// two stop bits. All outputs are registered; the next-state logic computes
// the level each output takes in the coming clock.
module uart_tx_frame_ctrl #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [1:0]        parity_mode,
    input  logic              two_stop,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    localparam int               BIT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_baud_cnt, w_baud_cnt_nxt;
    logic [BIT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic              r_par_bit, w_par_bit_nxt;
    logic              r_par_en, w_par_en_nxt;
    logic              r_two_stop, w_two_stop_nxt;
    logic              r_tx, w_tx_nxt;
    logic              r_ready, w_ready_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              w_accept;
    logic              w_bit_end;

    // Parity of the word: even when odd_sel=0, odd when odd_sel=1.
    function automatic logic f_parity(input logic [DATA_W-1:0] d, input logic odd_sel);
        return (^d) ^ odd_sel;
    endfunction

    // Modes 01 (even) and 10 (odd) add a parity bit; 00 and 11 do not.
    function automatic logic f_parity_en(input logic [1:0] mode);
        return (mode == 2'b01) || (mode == 2'b10);
    endfunction

    assign w_accept  = tx_valid && r_ready;
    assign w_bit_end = (r_baud_cnt == BAUD_LAST);

    // Next-state, datapath and next output levels.
    always_comb begin
        w_state_nxt    = r_state;
        w_baud_cnt_nxt = r_baud_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_par_bit_nxt  = r_par_bit;
        w_par_en_nxt   = r_par_en;
        w_two_stop_nxt = r_two_stop;
        w_tx_nxt       = 1'b1;

        if (r_state != S_IDLE) begin
            w_baud_cnt_nxt = w_bit_end ? '0 : r_baud_cnt + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_baud_cnt_nxt = '0;
                if (w_accept) begin
                    w_state_nxt    = S_START;
                    w_bit_cnt_nxt  = '0;
                    w_shift_nxt    = tx_data;
                    w_par_bit_nxt  = f_parity(tx_data, parity_mode[1]);
                    w_par_en_nxt   = f_parity_en(parity_mode);
                    w_two_stop_nxt = two_stop;
                end
            end
            S_START: begin
                if (w_bit_end) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = r_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end) begin
                    // Bit counter marks which stop bit is in progress.
                    if (r_two_stop && (r_bit_cnt == '0)) begin
                        w_bit_cnt_nxt = BIT_W'(1);
                    end else begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
            S_PARITY: w_tx_nxt = w_par_bit_nxt;
            default:  w_tx_nxt = 1'b1;
        endcase

        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_done_nxt  = (r_state == S_STOP) && (w_state_nxt == S_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Baud/bit counters, shift register and per-frame latched settings.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_par_en   <= 1'b0;
            r_two_stop <= 1'b0;
        end else begin
            r_baud_cnt <= w_baud_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_par_bit  <= w_par_bit_nxt;
            r_par_en   <= w_par_en_nxt;
            r_two_stop <= w_two_stop_nxt;
        end
    end

    // Registered outputs; reset drives the line idle-high immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_tx    <= w_tx_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign tx       = r_tx;
    assign tx_ready = r_ready;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
